// File: rtl/countdown_pkg.sv
// Shared types, default moduli and the load-clamp helper for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_UNITS_MOD = 10;
  localparam int unsigned DEF_TENS_MOD  = 6;
  localparam int unsigned DEF_W         = 4;

  function automatic int unsigned clamp_digit(input int unsigned val, input int unsigned modulus);
    return (val >= modulus) ? modulus - 1 : val;
  endfunction

endpackage

// File: rtl/mod_down_digit.sv
// One loadable modulo-MOD down-counting digit; borrows and wraps to MOD-1 when decremented at 0.
module mod_down_digit #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         borrow_out
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      q_d = (q_q == '0) ? W'(MOD - 1) : q_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec && (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit loadable countdown timer with start/stop/tick priority and one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to reload the start value on reaching 00.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned UNITS_MOD = DEF_UNITS_MOD,
  parameter int unsigned TENS_MOD  = DEF_TENS_MOD,
  parameter int unsigned W         = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] load_tens,
  input  logic [W-1:0] load_units,
  output logic [W-1:0] tens,
  output logic [W-1:0] units,
  output logic         running,
  output logic         done
);

  state_e       state_q, state_d;
  logic         done_q, done_d;
  logic         digit_load;
  logic         tick_en;
  logic         units_borrow;
  logic         tens_borrow_unused;
  logic [W-1:0] ld_tens, ld_units;
  logic [W-1:0] clamp_tens, clamp_units;
  logic         last_step;

  assign clamp_tens  = W'(clamp_digit(32'(load_tens), TENS_MOD));
  assign clamp_units = W'(clamp_digit(32'(load_units), UNITS_MOD));
  assign last_step   = (tens == '0) && (units == W'(1));

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [W-1:0] reload_tens_q, reload_units_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_tens_q  <= '0;
      reload_units_q <= '0;
    end else if (start) begin
      reload_tens_q  <= clamp_tens;
      reload_units_q <= clamp_units;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    digit_load = 1'b0;
    tick_en    = 1'b0;
    ld_tens    = clamp_tens;
    ld_units   = clamp_units;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          tick_en = 1'b1;
          if (last_step) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            // Digit load overrides the decrement, so the 01 step lands on the reload value.
            if ((reload_tens_q != '0) || (reload_units_q != '0)) begin
              digit_load = 1'b1;
              ld_tens    = reload_tens_q;
              ld_units   = reload_units_q;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      tick_en    = 1'b0;
      digit_load = 1'b1;
      ld_tens    = clamp_tens;
      ld_units   = clamp_units;
      if ((clamp_tens == '0) && (clamp_units == '0)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  mod_down_digit #(.MOD(UNITS_MOD), .W(W)) u_units (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (digit_load),
    .load_val   (ld_units),
    .dec        (tick_en),
    .q          (units),
    .borrow_out (units_borrow)
  );

  mod_down_digit #(.MOD(TENS_MOD), .W(W)) u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (digit_load),
    .load_val   (ld_tens),
    .dec        (units_borrow),
    .q          (tens),
    .borrow_out (tens_borrow_unused)
  );

  assign running = (state_q == ST_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default moduli 10/6, W=4).
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, start, stop;
  logic [3:0] load_tens, load_units;
  logic [3:0] tens, units;
  logic       running, done;

  int unsigned total  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  countdown_timer #(.UNITS_MOD(10), .TENS_MOD(6), .W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .load_tens  (load_tens),
    .load_units (load_units),
    .tens       (tens),
    .units      (units),
    .running    (running),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int unsigned t, input int unsigned u,
                            input logic r, input logic d);
    check({tag, ".tens"}, 32'(tens), 32'(t));
    check({tag, ".units"}, 32'(units), 32'(u));
    check({tag, ".running"}, 32'(running), 32'(r));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Drive one cycle of inputs around a single rising edge, then sample 1 ns after it.
  task automatic step(input logic s, input logic p, input logic t,
                      input logic [3:0] lt, input logic [3:0] lu);
    @(negedge clk);
    start = s; stop = p; tick = t; load_tens = lt; load_units = lu;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
    load_tens = '0; load_units = '0;
    #12;
    expect_out("reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-run at 3:7.
    step(1'b1, 1'b0, 1'b0, 4'd3, 4'd7);
    expect_out("run37", 3, 7, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Borrow from units into tens.
    step(1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("borrow30", 2, 9, 1'b1, 1'b0);

    // Priority: start beats stop and tick; stop beats tick.
    step(1'b1, 1'b0, 1'b0, 4'd4, 4'd4);
    expect_out("load44", 4, 4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'd2, 4'd5);
    expect_out("prio_start", 2, 5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    expect_out("prio_stop", 2, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("idle_tick", 2, 5, 1'b0, 1'b0);

    // Clamp and zero-load.
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'd15);
    expect_out("clamp9F", 5, 9, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    expect_out("zero_load", 0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("zero_after", 0, 0, 1'b0, 1'b0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd2);
    expect_out("ar_load", 0, 2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("ar_t1", 0, 1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("ar_t2", 0, 2, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("ar_t3", 0, 1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("ar_t4", 0, 2, 1'b1, 1'b1);
`else
    // 12 down to 00 with done only on the final step.
    step(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
    expect_out("load12", 1, 2, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      expect_out($sformatf("seq12_%0d", k), (12 - k) / 10, (12 - k) % 10,
                 (k < 12), (k == 12));
    end
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_out("done_hold1", 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    expect_out("done_hold2", 0, 0, 1'b0, 1'b0);

    // 0:9 down to 00 without tens underflow.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      expect_out($sformatf("seq09_%0d", k), 0, 9 - k, (k < 9), (k == 9));
    end
`endif

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
